// File: rtl/router_mesh_xy_np.sv
// router_mesh_xy_np
//   Single-flit packet router for one tile of a 2-D mesh NoC. There are up to
//   five ports (0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH). PORT_EN removes
//   the ports that a corner or border tile does not have. Each input has a
//   FIFO. The FIFO head is routed X first, then Y. Each output has its own
//   round-robin arbiter and a registered output stage.
//   A head flit is dropped when its route is a disabled port or a U-turn.
//   A write into a full FIFO is also dropped. Both kinds of drop add to
//   drop_cnt, which saturates.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   in_data    5 x DATA_WIDTH flits, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-input write strobe
//   in_full    per-input almost-full (count >= FIFO_DEPTH-2), to upstream
//   out_data   5 x DATA_WIDTH registered output flits
//   out_valid  per-output registered valid
//   out_full   per-output almost-full from the downstream receivers
//   drop_cnt   saturating count of dropped flits
module router_mesh_xy_np #(
   parameter int         DATA_WIDTH = 32,
   parameter int         FIFO_DEPTH = 8,
   parameter int         X_BITS     = 2,
   parameter int         Y_BITS     = 1,
   parameter int         ROUTER_X   = 0,
   parameter int         ROUTER_Y   = 0,
   parameter logic [4:0] PORT_EN    = 5'b11111
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5*DATA_WIDTH-1:0] in_data,
   input  logic [4:0]              in_valid,
   output logic [4:0]              in_full,
   output logic [5*DATA_WIDTH-1:0] out_data,
   output logic [4:0]              out_valid,
   input  logic [4:0]              out_full,
   output logic [15:0]             drop_cnt
);

   localparam int NP    = 5;
   localparam int DW    = DATA_WIDTH;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int DST_W = X_BITS + Y_BITS;

   localparam logic [X_BITS-1:0] MY_X = X_BITS'(ROUTER_X);
   localparam logic [Y_BITS-1:0] MY_Y = Y_BITS'(ROUTER_Y);

   localparam logic [2:0] P_LOCAL = 3'd0;
   localparam logic [2:0] P_EAST  = 3'd1;
   localparam logic [2:0] P_WEST  = 3'd2;
   localparam logic [2:0] P_NORTH = 3'd3;
   localparam logic [2:0] P_SOUTH = 3'd4;

   // Dimension-ordered route: resolve X completely before looking at Y.
   function automatic logic [2:0] xy_route(input logic [DST_W-1:0] dst);
      logic [X_BITS-1:0] dx;
      logic [Y_BITS-1:0] dy;
      dx = dst[X_BITS-1:0];
      dy = dst[DST_W-1:X_BITS];
      if (dx > MY_X)      return P_EAST;
      else if (dx < MY_X) return P_WEST;
      else if (dy > MY_Y) return P_NORTH;
      else if (dy < MY_Y) return P_SOUTH;
      else                return P_LOCAL;
   endfunction

   // (base + k) mod 5, for k in 0..4
   function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NP) s = s - NP;
      return 3'(s);
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [3:0] inc);
      logic [16:0] s;
      s = {1'b0, cnt} + 17'(inc);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [DW-1:0]    fifo_mem [NP][FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr   [NP];
   logic [AW-1:0]    rd_ptr   [NP];
   logic [CW-1:0]    count    [NP];
   logic [2:0]       rr_ptr   [NP];
   logic [DW-1:0]    head     [NP];
   logic [2:0]       route    [NP];
   logic [2:0]       gnt_src  [NP];
   logic [NP-1:0]    nonempty, drop_head, req_vld, wr_en, wr_acc, ovf, pop, gnt_vld;
   logic [3:0]       drop_inc;
   logic [NP*DW-1:0] data_p1;
   logic [NP-1:0]    vld_p1;
   logic [15:0]      drop_cnt_q;

   // Stage 0: input FIFOs, route compute and drop decision on each head
   for (genvar i = 0; i < NP; i++) begin : g_in
      assign head[i]      = fifo_mem[i][rd_ptr[i]];
      assign route[i]     = xy_route(head[i][DST_W-1:0]);
      assign nonempty[i]  = (count[i] != '0);
      assign drop_head[i] = nonempty[i] &&
                            (!PORT_EN[route[i]] || (i != 0 && route[i] == 3'(i)));
      assign req_vld[i]   = nonempty[i] && !drop_head[i];
      assign in_full[i]   = PORT_EN[i] && (count[i] >= CW'(FIFO_DEPTH - 2));
      assign wr_en[i]     = in_valid[i] && PORT_EN[i];
      // A full FIFO still accepts a write in a cycle where its head pops.
      assign wr_acc[i]    = wr_en[i] && ((count[i] != CW'(FIFO_DEPTH)) || pop[i]);
      assign ovf[i]       = wr_en[i] && !wr_acc[i];
   end

   // Each input requests exactly one output, so per-output grants never collide.
   always_comb begin
      gnt_vld = '0;
      for (int o = 0; o < NP; o++) gnt_src[o] = '0;
      for (int o = 0; o < NP; o++) begin
         if (PORT_EN[o] && !out_full[o]) begin
            for (int k = 0; k < NP; k++) begin
               if (!gnt_vld[o] && req_vld[rr_idx(rr_ptr[o], k)] &&
                   route[rr_idx(rr_ptr[o], k)] == 3'(o)) begin
                  gnt_vld[o] = 1'b1;
                  gnt_src[o] = rr_idx(rr_ptr[o], k);
               end
            end
         end
      end
      pop = drop_head;
      for (int o = 0; o < NP; o++)
         if (gnt_vld[o]) pop[gnt_src[o]] = 1'b1;
   end

   assign drop_inc = 4'($countones(drop_head)) + 4'($countones(ovf));

   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++)
         if (wr_acc[i] && !rst) fifo_mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
   end

   // Stage 1: registered outputs, arbitration pointers, drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
            rr_ptr[i] <= '0;
         end
         vld_p1     <= '0;
         data_p1    <= '0;
         drop_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (wr_acc[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])    rd_ptr[i] <= rd_ptr[i] + 1'b1;
            count[i] <= count[i] + CW'(wr_acc[i]) - CW'(pop[i]);
         end
         for (int o = 0; o < NP; o++) begin
            vld_p1[o]            <= gnt_vld[o];
            data_p1[o*DW +: DW]  <= gnt_vld[o] ? head[gnt_src[o]] : '0;
            if (gnt_vld[o]) rr_ptr[o] <= rr_idx(gnt_src[o], 1);
         end
         drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
      end
   end

   assign out_data  = data_p1;
   assign out_valid = vld_p1;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/router_mesh_xy_np.md
Name: router_mesh_xy_np

Overview:
- Parametrised successor to the 3-port border router; single-flit packet router for 2-D mesh NoC tiles.
- Up to 5 ports: LOCAL, EAST, WEST, NORTH, SOUTH. PORT_EN mask lets one module serve corner, border and interior tiles.
- Each input has a FIFO. Dimension-ordered XY routing; per-output round-robin arbitration; registered outputs with almost-full back-pressure.
- Replaces fixed 3-port routers in larger meshes.

Parameters:
- DATA_WIDTH, 32, flit width. Destination field is in the low X_BITS+Y_BITS bits.
- FIFO_DEPTH, 8, entries per input FIFO. Power of 2, minimum 4.
- X_BITS, 2, width of the X coordinate, located at flit[X_BITS-1:0].
- Y_BITS, 1, width of the Y coordinate, located at flit[X_BITS+Y_BITS-1:X_BITS].
- ROUTER_X, 0, this tile's X coordinate.
- ROUTER_Y, 0, this tile's Y coordinate.
- PORT_EN, 5'b11111, enable mask indexed by port number: 0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  5*DATA_WIDTH  flit per input port; port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  5  write strobe per input.
- in_full  out  5  almost-full per input FIFO, sent to the upstream sender.
- out_data  out  5*DATA_WIDTH  registered flit per output port.
- out_valid  out  5  registered valid per output.
- out_full  in  5  almost-full from each downstream receiver.
- drop_cnt  out  16  saturating count of dropped flits.

Behaviour:
- Reset: synchronous. At the next posedge with rst=1:
  - All FIFOs empty; round-robin pointers = 0.
  - out_data=0, out_valid=0, drop_cnt=0, in_full=0.
  - in_valid is ignored while rst=1. Reset asserted mid-operation discards in-flight flits without emitting partial outputs.
- Disabled ports (PORT_EN[p]=0):
  - in_valid[p] ignored; in_full[p]=0.
  - out_valid[p]=0 and out_data[p]=0 permanently.
- Input FIFO:
  - Written when in_valid[p]=1.
  - in_full[p]=1 when count >= FIFO_DEPTH-2. This 2-slot slack covers one registered-output cycle plus one count-update cycle.
  - A write while count==FIFO_DEPTH is lost and increments drop_cnt. A simultaneous read and write at full is legal.
- Route compute (combinational on each FIFO head):
  - dst_x > ROUTER_X gives EAST; dst_x < ROUTER_X gives WEST.
  - Otherwise dst_y > ROUTER_Y gives NORTH; dst_y < ROUTER_Y gives SOUTH.
  - Otherwise the route is LOCAL.
- Drop rule: a head flit is dropped when its computed port is disabled, or equals its own non-LOCAL input port (U-turn).
  - The flit is popped without output and drop_cnt increments, in 1 cycle.
  - drop_cnt saturates at 16'hFFFF.
  - When several inputs drop in the same cycle, drop_cnt increases by the number of drops, saturating.
- Arbitration, per output o:
  - Requesters are non-empty, non-dropping heads routed to o.
  - A grant is issued only if out_full[o]=0.
  - Round-robin: search starts at ptr[o]. After a grant to input i, ptr[o] = (i+1) mod 5.
  - With no grant, ptr[o] holds.
  - Each input requests one output only, so grants never conflict.
- Output stage:
  - A grant at cycle t pops the FIFO head at edge t and registers out_data[o]=flit, out_valid[o]=1 for cycle t+1.
  - With no grant, out_valid[o]=0 and out_data[o]=0 next cycle.
- Latency: a flit written at edge t into an empty FIFO, with the output free, appears on out_valid at cycle t+2.
- Throughput: 1 flit/cycle per output. Contention is served fairly.
- Ordering: flits from the same input to the same output leave in FIFO order.
- out_full asserted mid-stream: no new grants from the next sampling cycle onward. A flit already registered still completes.

Test Plan:
- Straight routing: ROUTER_X=1, ROUTER_Y=0. Inject at LOCAL flit dst x=3,y=0 (data 32'hA5A5_0003) at cycle 0 -> out_valid[EAST]=1 with the same data at cycle 2; all other out_valid=0.
- Round-robin: WEST, NORTH and LOCAL each send 4 flits to LOCAL dst (x=1,y=0) continuously -> LOCAL output grant order LOCAL, WEST, NORTH repeating; 12 flits delivered in 12 consecutive cycles; per-source order preserved.
- Back-pressure: hold out_full[EAST]=1 for 10 cycles while LOCAL streams 8 EAST-bound flits -> no out_valid[EAST]; in_full[LOCAL] rises when count reaches 6. Release -> all 8 flits out in order with no loss and drop_cnt=0.
- Border/drop: PORT_EN=5'b00111, ROUTER_Y=0; LOCAL flit with dst y=1 -> popped, no output, drop_cnt=1. EAST-input flit routed EAST -> dropped, drop_cnt=2.
- Overflow: ignore in_full[WEST] and write 10 flits with out_full all 1 -> 8 stored, drop_cnt=2.
- Reset mid-stream: assert rst for 1 cycle during a 4-flit burst -> next cycle all out_valid=0, drop_cnt=0, FIFOs empty; a new flit after reset has 2-cycle latency.
